// File: rtl/ram_slot_arbiter_if.sv
// Bus bundle between the three SRAM requesters (CPU, video, MCU) and the slot arbiter.
interface ram_slot_arbiter_if #(
    parameter int ADDR_WIDTH = 17
);
    // Handshake: mcu_req_i is a level the master holds until the one-clock mcu_ack_o; the
    // arbiter samples mcu_addr_i/mcu_we_i at grant. CPU and video inputs have no ready side:
    // they are sampled at the start of their slot and completion is signalled by cpu_en_o /
    // vid_strobe_o.
    logic [ADDR_WIDTH-1:0] cpu_addr_i;
    logic                  cpu_we_i;
    logic                  vid_req_i;
    logic [ADDR_WIDTH-1:0] vid_addr_i;
    logic                  mcu_req_i;
    logic [ADDR_WIDTH-1:0] mcu_addr_i;
    logic                  mcu_we_i;
    logic [ADDR_WIDTH-1:0] ram_addr_o;
    logic                  ram_oe_n_o;
    logic                  ram_we_n_o;
    logic [1:0]            grant_o;
    logic                  cpu_en_o;
    logic                  vid_strobe_o;
    logic                  mcu_ack_o;

    modport master (
        output cpu_addr_i, cpu_we_i, vid_req_i, vid_addr_i, mcu_req_i, mcu_addr_i, mcu_we_i,
        input  ram_addr_o, ram_oe_n_o, ram_we_n_o, grant_o, cpu_en_o, vid_strobe_o, mcu_ack_o
    );

    modport slave (
        input  cpu_addr_i, cpu_we_i, vid_req_i, vid_addr_i, mcu_req_i, mcu_addr_i, mcu_we_i,
        output ram_addr_o, ram_oe_n_o, ram_we_n_o, grant_o, cpu_en_o, vid_strobe_o, mcu_ack_o
    );
endinterface

// File: rtl/ram_slot_arbiter.sv
// Shared SRAM slot scheduler: four 4-clock slots per 16-clock CPU cycle (CPU, video, video, MCU),
// registered address/strobes and one-clock completion pulses per owner.
module ram_slot_arbiter #(
    parameter int ADDR_WIDTH        = 17,
    parameter bit MCU_USES_VID_SLOT = 1'b1
) (
    input logic               clk16_i,
    input logic               reset_n_i,
    ram_slot_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_VID  = 2'd2,
        OWN_MCU  = 2'd3
    } owner_e;

    logic [3:0]            cnt_q, cnt_d;
    logic                  run_q, run_d;
    owner_e                owner_q, owner_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic                  oe_n_q, oe_n_d;
    logic                  we_n_q, we_n_d;
    logic                  cpu_en_q, cpu_en_d;
    logic                  vid_strobe_q, vid_strobe_d;
    logic                  mcu_ack_q, mcu_ack_d;
    logic                  mcu_block_q, mcu_block_d;
    logic                  mcu_ok;
    logic                  access;
    logic                  done;

    always_comb begin
        // run_q is clear only out of reset, so the first edge lands on cnt=0 rather than 1.
        cnt_d        = run_q ? (cnt_q + 4'd1) : 4'd0;
        run_d        = 1'b1;
        owner_d      = owner_q;
        addr_d       = addr_q;
        we_d         = we_q;
        mcu_block_d  = mcu_block_q;
        mcu_ok       = bus.mcu_req_i & ~mcu_block_q;
        access       = 1'b0;
        done         = 1'b0;

        if (cnt_d[1:0] == 2'd0) begin
            // The block only covers the one decision right after an ack.
            mcu_block_d = 1'b0;
            owner_d     = OWN_IDLE;
            addr_d      = '0;
            we_d        = 1'b0;
            unique case (cnt_d[3:2])
                2'd0: begin
                    owner_d = OWN_CPU;
                    addr_d  = bus.cpu_addr_i;
                    we_d    = bus.cpu_we_i;
                end
                2'd1, 2'd2: begin
                    if (bus.vid_req_i) begin
                        owner_d = OWN_VID;
                        addr_d  = bus.vid_addr_i;
                    end else if (MCU_USES_VID_SLOT && mcu_ok) begin
                        owner_d = OWN_MCU;
                        addr_d  = bus.mcu_addr_i;
                        we_d    = bus.mcu_we_i;
                    end
                end
                default: begin
                    if (mcu_ok) begin
                        owner_d = OWN_MCU;
                        addr_d  = bus.mcu_addr_i;
                        we_d    = bus.mcu_we_i;
                    end
                end
            endcase
        end

        access = (owner_d != OWN_IDLE) && ((cnt_d[1:0] == 2'd1) || (cnt_d[1:0] == 2'd2));
        done   = (cnt_d[1:0] == 2'd3);

        oe_n_d       = ~(access & ~we_d);
        we_n_d       = ~(access & we_d);
        cpu_en_d     = done && (owner_d == OWN_CPU);
        vid_strobe_d = done && (owner_d == OWN_VID);
        mcu_ack_d    = done && (owner_d == OWN_MCU);

        if (mcu_ack_d) begin
            mcu_block_d = 1'b1;
        end
    end

    always_ff @(posedge clk16_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q        <= 4'd0;
            run_q        <= 1'b0;
            owner_q      <= OWN_IDLE;
            addr_q       <= '0;
            we_q         <= 1'b0;
            oe_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            cpu_en_q     <= 1'b0;
            vid_strobe_q <= 1'b0;
            mcu_ack_q    <= 1'b0;
            mcu_block_q  <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            run_q        <= run_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            oe_n_q       <= oe_n_d;
            we_n_q       <= we_n_d;
            cpu_en_q     <= cpu_en_d;
            vid_strobe_q <= vid_strobe_d;
            mcu_ack_q    <= mcu_ack_d;
            mcu_block_q  <= mcu_block_d;
        end
    end

    assign bus.ram_addr_o   = addr_q;
    assign bus.ram_oe_n_o   = oe_n_q;
    assign bus.ram_we_n_o   = we_n_q;
    assign bus.grant_o      = owner_q;
    assign bus.cpu_en_o     = cpu_en_q;
    assign bus.vid_strobe_o = vid_strobe_q;
    assign bus.mcu_ack_o    = mcu_ack_q;

endmodule

// File: tb/tb_ram_slot_arbiter.sv
// Directed and randomized bench for ram_slot_arbiter against a slot-level reference model
// (global time index t since reset release; slot number n = t/4).
module tb_ram_slot_arbiter;

    localparam int AW = 17;

    logic clk;
    logic rst_n;

    ram_slot_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

    ram_slot_arbiter #(.ADDR_WIDTH(AW), .MCU_USES_VID_SLOT(1'b1)) dut (
        .clk16_i   (clk),
        .reset_n_i (rst_n),
        .bus       (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard / model state ----------------
    int            checks = 0;
    int            passed = 0;
    int            t;
    int            last_ack_n;
    logic [1:0]    m_owner;
    logic [AW-1:0] m_addr;
    logic          m_we;
    logic [1:0]    e_grant;
    logic [AW-1:0] e_addr;
    logic          e_oe_n, e_we_n, e_cpu_en, e_vid, e_ack;
    logic [AW-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp_v, t);
    endtask

    task automatic model_reset();
        t          = -1;
        last_ack_n = -100;
        m_owner    = 2'd0;
        m_addr     = '0;
        m_we       = 1'b0;
        exp_q.delete();
    endtask

    // Expected bus state right after the edge that moves time to t.
    task automatic model_update();
        int ph, sl, n;
        ph = t % 4;
        sl = (t / 4) % 4;
        n  = t / 4;
        if (ph == 0) begin
            m_owner = 2'd0;
            m_addr  = '0;
            m_we    = 1'b0;
            if (sl == 0) begin
                m_owner = 2'd1;
                m_addr  = bus.cpu_addr_i;
                m_we    = bus.cpu_we_i;
            end else if (sl != 3 && bus.vid_req_i) begin
                m_owner = 2'd2;
                m_addr  = bus.vid_addr_i;
            end else if (bus.mcu_req_i && (n != last_ack_n + 1)) begin
                m_owner = 2'd3;
                m_addr  = bus.mcu_addr_i;
                m_we    = bus.mcu_we_i;
                exp_q.push_back(bus.mcu_addr_i);
            end
        end
        e_grant  = m_owner;
        e_addr   = m_addr;
        e_oe_n   = !((m_owner != 2'd0) && !m_we && (ph == 1 || ph == 2));
        e_we_n   = !((m_owner != 2'd0) && m_we && (ph == 1 || ph == 2));
        e_cpu_en = (m_owner == 2'd1) && (ph == 3);
        e_vid    = (m_owner == 2'd2) && (ph == 3);
        e_ack    = (m_owner == 2'd3) && (ph == 3);
        if (e_ack) last_ack_n = n;
    endtask

    task automatic compare_all();
        logic [AW-1:0] a;
        chk("grant", 32'(bus.grant_o), 32'(e_grant));
        chk("ram_addr", 32'(bus.ram_addr_o), 32'(e_addr));
        chk("oe_n", 32'(bus.ram_oe_n_o), 32'(e_oe_n));
        chk("we_n", 32'(bus.ram_we_n_o), 32'(e_we_n));
        chk("strobe_excl", 32'(bus.ram_oe_n_o | bus.ram_we_n_o), 32'd1);
        chk("cpu_en", 32'(bus.cpu_en_o), 32'(e_cpu_en));
        chk("vid_strobe", 32'(bus.vid_strobe_o), 32'(e_vid));
        chk("mcu_ack", 32'(bus.mcu_ack_o), 32'(e_ack));
        if (bus.mcu_ack_o === 1'b1) begin
            if (exp_q.size() > 0) begin
                a = exp_q.pop_front();
                chk("mcu_ack_addr", 32'(bus.ram_addr_o), 32'(a));
            end else begin
                chk("mcu_ack_spurious", 32'(exp_q.size()), 32'd1);
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        t++;
        model_update();
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        bus.cpu_addr_i = '0;
        bus.cpu_we_i   = 1'b0;
        bus.vid_req_i  = 1'b0;
        bus.vid_addr_i = '0;
        bus.mcu_req_i  = 1'b0;
        bus.mcu_addr_i = '0;
        bus.mcu_we_i   = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_grant"}, 32'(bus.grant_o), 32'd0);
        chk({tag, "_addr"}, 32'(bus.ram_addr_o), 32'd0);
        chk({tag, "_oe_n"}, 32'(bus.ram_oe_n_o), 32'd1);
        chk({tag, "_we_n"}, 32'(bus.ram_we_n_o), 32'd1);
        chk({tag, "_pulses"}, 32'({bus.cpu_en_o, bus.vid_strobe_o, bus.mcu_ack_o}), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        #2 rst_n = 1'b1;

        // 1: no requests, CPU reads every frame, other slots idle
        for (int i = 0; i < 48; i++) begin
            step();
            if (t == 3 || t == 19 || t == 35) chk("t1_cpu_en", 32'(bus.cpu_en_o), 32'd1);
            if (t % 16 == 1 || t % 16 == 2) chk("t1_oe_low", 32'(bus.ram_oe_n_o), 32'd0);
        end

        // 2: CPU write
        bus.cpu_addr_i = 17'h08000;
        bus.cpu_we_i   = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            if (t % 16 <= 3) chk("t2_addr", 32'(bus.ram_addr_o), 32'h08000);
            if (t % 16 == 1 || t % 16 == 2) chk("t2_we_low", 32'(bus.ram_we_n_o), 32'd0);
            if (t % 16 == 3) chk("t2_cpu_en", 32'(bus.cpu_en_o), 32'd1);
        end
        bus.cpu_we_i = 1'b0;

        // 3: video fetch holds slots 1 and 2
        bus.vid_req_i  = 1'b1;
        bus.vid_addr_i = 17'h08010;
        for (int i = 0; i < 16; i++) begin
            step();
            if (t % 16 == 5 || t % 16 == 9) chk("t3_grant_vid", 32'(bus.grant_o), 32'd2);
            if (t % 16 == 7 || t % 16 == 11) chk("t3_vid_strobe", 32'(bus.vid_strobe_o), 32'd1);
        end
        bus.vid_req_i = 1'b0;

        // 4: MCU read takes slot 1, sits out slot 2 after its ack, wins slot 3
        bus.mcu_req_i  = 1'b1;
        bus.mcu_addr_i = 17'h1F000;
        bus.mcu_we_i   = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (t % 16 == 5) chk("t4_grant_mcu", 32'(bus.grant_o), 32'd3);
            if (t % 16 == 7 || t % 16 == 15) chk("t4_ack", 32'(bus.mcu_ack_o), 32'd1);
            if (t % 16 == 9) chk("t4_slot2_idle", 32'(bus.grant_o), 32'd0);
        end

        // 5: video and MCU together: video wins 1/2, MCU gets 3
        bus.vid_req_i  = 1'b1;
        bus.mcu_addr_i = 17'h00123;
        bus.mcu_we_i   = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            if (t % 16 == 5 || t % 16 == 9) chk("t5_grant_vid", 32'(bus.grant_o), 32'd2);
            if (t % 16 == 13) chk("t5_mcu_we_low", 32'(bus.ram_we_n_o), 32'd0);
            if (t % 16 == 15) chk("t5_ack", 32'(bus.mcu_ack_o), 32'd1);
        end
        bus.mcu_req_i = 1'b0;
        bus.vid_req_i = 1'b0;

        // randomized traffic; the MCU sometimes keeps its request up past the ack
        for (int i = 0; i < 800; i++) begin
            bus.cpu_addr_i = AW'($urandom);
            bus.cpu_we_i   = 1'($urandom_range(0, 1));
            bus.vid_req_i  = ($urandom_range(0, 2) == 0);
            bus.vid_addr_i = AW'($urandom);
            if (!bus.mcu_req_i && $urandom_range(0, 3) == 0) begin
                bus.mcu_req_i  = 1'b1;
                bus.mcu_addr_i = AW'($urandom);
                bus.mcu_we_i   = 1'($urandom_range(0, 1));
            end else if (bus.mcu_req_i && $urandom_range(0, 19) == 0) begin
                bus.mcu_req_i = 1'b0;
            end
            step();
            if (bus.mcu_ack_o === 1'b1 && $urandom_range(0, 3) != 0) bus.mcu_req_i = 1'b0;
        end

        // 6: reset during a video read aborts it with no strobe
        idle_inputs();
        for (int i = 0; i < 16 && (t % 16) != 15; i++) step();
        bus.vid_req_i  = 1'b1;
        bus.vid_addr_i = 17'h0ABCD;
        for (int i = 0; i < 6; i++) step();
        chk("t6_at_cnt5", 32'(t % 16), 32'd5);
        chk("t6_oe_low_before", 32'(bus.ram_oe_n_o), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check_reset_outputs("t6_held");
        end
        #2 rst_n = 1'b1;
        model_reset();
        bus.vid_req_i = 1'b0;
        for (int i = 0; i < 32; i++) begin
            step();
            if (t == 3) chk("t6_cpu_en_after", 32'(bus.cpu_en_o), 32'd1);
        end

        idle_inputs();
        for (int i = 0; i < 16; i++) step();
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
